// File: rtl/enqueue_agent_v2_pkg.sv
// Shared types and helpers for the enqueue agent: FSM states, drop-mode
// encodings, default destination-flag position and the grant function.
package enqueue_agent_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } state_e;

    localparam int PARTIAL         = 0;
    localparam int ALL_OR_NONE     = 1;
    localparam int DST_POS_DEFAULT = 24;
    localparam int MAX_PORTS       = 8;

    // Ports are zero-extended to MAX_PORTS so one function serves every NUM_PORTS.
    function automatic logic [MAX_PORTS-1:0] calc_grant(
        input logic [MAX_PORTS-1:0] dst,
        input logic [MAX_PORTS-1:0] almost_full,
        input logic                 all_or_none
    );
        logic [MAX_PORTS-1:0] conflict;
        conflict = dst & almost_full;
        if (all_or_none && (conflict != '0)) begin
            calc_grant = '0;
        end else begin
            calc_grant = dst & ~almost_full;
        end
    endfunction

endpackage

// File: rtl/enqueue_agent_v2_if.sv
// Pipeline-to-agent stream plus per-port buffer/PIFO control bundle.
// Handshake: a beat transfers on a rising edge where s_axis_tvalid && s_axis_tready are both 1.
interface enqueue_agent_v2_if
    import enqueue_agent_pkg::*;
#(
    parameter int NUM_PORTS   = 5,
    parameter int TUSER_WIDTH = 128
);
    logic                   s_axis_tvalid;
    logic                   s_axis_tready;
    logic [TUSER_WIDTH-1:0] s_axis_tuser;
    logic                   s_axis_tlast;
    logic [NUM_PORTS-1:0]   s_axis_buffer_almost_full;
    logic [NUM_PORTS-1:0]   m_axis_ctl_buffer_wr_en;
    logic [NUM_PORTS-1:0]   m_axis_ctl_pifo_in_en;
    state_e                 dbg_state;

    modport master (
        output s_axis_tvalid, s_axis_tuser, s_axis_tlast, s_axis_buffer_almost_full,
        input  s_axis_tready, m_axis_ctl_buffer_wr_en, m_axis_ctl_pifo_in_en, dbg_state
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tuser, s_axis_tlast, s_axis_buffer_almost_full,
        output s_axis_tready, m_axis_ctl_buffer_wr_en, m_axis_ctl_pifo_in_en, dbg_state
    );
endinterface

// File: rtl/enqueue_agent_v2.sv
// Enqueue agent: grants a packet to its non-full destination ports on the first beat and
// drives per-beat buffer writes and a per-packet PIFO pulse. Drop counter: ENQ_AGENT_DROP_CNT_EN.
module enqueue_agent_v2
    import enqueue_agent_pkg::*;
#(
    parameter int NUM_PORTS   = 5,
    parameter int TUSER_WIDTH = 128,
    parameter int DST_POS     = DST_POS_DEFAULT,
    parameter int DROP_MODE   = PARTIAL
) (
    input  logic                axis_aclk,
    input  logic                axis_resetn,
    enqueue_agent_v2_if.slave   bus
`ifdef ENQ_AGENT_DROP_CNT_EN
    ,
    output logic [31:0]         m_drop_count
`endif
);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic                   r_tready;
    logic [NUM_PORTS-1:0]   r_grant;
    logic [NUM_PORTS-1:0]   r_wr_en;
    logic [NUM_PORTS-1:0]   r_pifo_en;
    logic [NUM_PORTS-1:0]   w_dst;
    logic [NUM_PORTS-1:0]   w_grant_first;
    logic [NUM_PORTS-1:0]   w_grant_cur;
    logic [MAX_PORTS-1:0]   w_dst_ext;
    logic [MAX_PORTS-1:0]   w_af_ext;
    logic [MAX_PORTS-1:0]   w_grant_ext;
    logic                   w_accept;
    logic                   w_last_beat;
    logic                   w_unused_bits;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_dst
        assign w_dst[i] = bus.s_axis_tuser[DST_POS + 2*i];
    end

    always_comb begin
        w_dst_ext                = '0;
        w_af_ext                 = '0;
        w_dst_ext[NUM_PORTS-1:0] = w_dst;
        w_af_ext[NUM_PORTS-1:0]  = bus.s_axis_buffer_almost_full;
    end

    assign w_grant_ext   = calc_grant(w_dst_ext, w_af_ext, DROP_MODE == ALL_OR_NONE);
    assign w_grant_first = w_grant_ext[NUM_PORTS-1:0];
    assign w_unused_bits = ^{bus.s_axis_tuser, w_grant_ext};

    assign w_accept    = bus.s_axis_tvalid & r_tready;
    assign w_last_beat = w_accept & bus.s_axis_tlast;
    // The first beat uses the live grant; later beats reuse the latched one.
    assign w_grant_cur = (r_state == ST_IDLE) ? w_grant_first : r_grant;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !bus.s_axis_tlast) begin
                    w_state_nxt = (w_grant_first != '0) ? ST_WRITE : ST_DROP;
                end
            end
            ST_WRITE, ST_DROP: begin
                if (w_last_beat) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_state   <= ST_IDLE;
            r_tready  <= 1'b0;
            r_grant   <= '0;
            r_wr_en   <= '0;
            r_pifo_en <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tready  <= 1'b1;
            if (w_accept && (r_state == ST_IDLE)) begin
                r_grant <= w_grant_first;
            end
            r_wr_en   <= w_accept    ? w_grant_cur : '0;
            r_pifo_en <= w_last_beat ? w_grant_cur : '0;
        end
    end

`ifdef ENQ_AGENT_DROP_CNT_EN
    logic        w_drop_evt;
    logic [31:0] r_drop_count;

    assign w_drop_evt = w_last_beat && (w_grant_cur == '0);

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_drop_count <= '0;
        end else if (w_drop_evt && (r_drop_count != 32'hFFFF_FFFF)) begin
            r_drop_count <= r_drop_count + 32'd1;
        end
    end

    assign m_drop_count = r_drop_count;
`endif

    assign bus.s_axis_tready           = r_tready;
    assign bus.m_axis_ctl_buffer_wr_en = r_wr_en;
    assign bus.m_axis_ctl_pifo_in_en   = r_pifo_en;
    assign bus.dbg_state               = r_state;

endmodule

// File: tb/tb_enqueue_agent_v2.sv
// Bench for enqueue_agent_v2: a PARTIAL and an ALL_OR_NONE instance share one stimulus
// stream; directed vector table, mid-packet reset sequence, then randomized traffic.
module tb_enqueue_agent_v2;
    import enqueue_agent_pkg::*;

    localparam int NP = 5;
    localparam int TW = 128;
    localparam int DP = 24;

    logic clk;
    logic resetn;

    enqueue_agent_v2_if #(.NUM_PORTS(NP), .TUSER_WIDTH(TW)) bus0 ();
    enqueue_agent_v2_if #(.NUM_PORTS(NP), .TUSER_WIDTH(TW)) bus1 ();

    assign bus1.s_axis_tvalid             = bus0.s_axis_tvalid;
    assign bus1.s_axis_tuser              = bus0.s_axis_tuser;
    assign bus1.s_axis_tlast              = bus0.s_axis_tlast;
    assign bus1.s_axis_buffer_almost_full = bus0.s_axis_buffer_almost_full;

`ifdef ENQ_AGENT_DROP_CNT_EN
    logic [31:0] drop0;
    logic [31:0] drop1;
`endif

    enqueue_agent_v2 #(.NUM_PORTS(NP), .TUSER_WIDTH(TW), .DST_POS(DP), .DROP_MODE(0)) dut0 (
        .axis_aclk   (clk),
        .axis_resetn (resetn),
        .bus         (bus0)
`ifdef ENQ_AGENT_DROP_CNT_EN
        ,
        .m_drop_count(drop0)
`endif
    );

    enqueue_agent_v2 #(.NUM_PORTS(NP), .TUSER_WIDTH(TW), .DST_POS(DP), .DROP_MODE(1)) dut1 (
        .axis_aclk   (clk),
        .axis_resetn (resetn),
        .bus         (bus1)
`ifdef ENQ_AGENT_DROP_CNT_EN
        ,
        .m_drop_count(drop1)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: packet-level view of grants and drops
    logic        m_in_pkt;
    logic [NP-1:0] m_grant0, m_grant1;
    int          m_drops0, m_drops1;
    logic [4*NP-1:0] exp_q[$];

    function automatic logic [NP-1:0] model_grant(input logic [TW-1:0] tuser,
                                                  input logic [NP-1:0] af, input int mode);
        logic [NP-1:0] g;
        bit            conflict;
        g        = '0;
        conflict = 0;
        for (int i = 0; i < NP; i++) begin
            if (tuser[DP + 2*i]) begin
                if (af[i]) conflict = 1;
                else       g[i] = 1'b1;
            end
        end
        if (mode == 1 && conflict) g = '0;
        return g;
    endfunction

    function automatic logic [TW-1:0] mk_tuser(input logic [NP-1:0] mask);
        logic [TW-1:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < NP; i++) t[DP + 2*i] = mask[i];
        return t;
    endfunction

    task automatic model_reset();
        m_in_pkt = 1'b0;
        m_grant0 = '0;
        m_grant1 = '0;
        m_drops0 = 0;
        m_drops1 = 0;
    endtask

    // driver: called at a falling edge, returns at the next falling edge
    task automatic do_cycle(input logic v, input logic [NP-1:0] mask, input logic last,
                            input logic [NP-1:0] af,
                            output logic [NP-1:0] wr0, output logic [NP-1:0] p0,
                            output logic [NP-1:0] wr1, output logic [NP-1:0] p1);
        logic [TW-1:0]   tuser;
        logic [NP-1:0]   ew0, ep0, ew1, ep1;
        logic [4*NP-1:0] e;
        tuser = mk_tuser(mask);
        bus0.s_axis_tvalid             = v;
        bus0.s_axis_tuser              = tuser;
        bus0.s_axis_tlast              = last;
        bus0.s_axis_buffer_almost_full = af;
        ew0 = '0; ep0 = '0; ew1 = '0; ep1 = '0;
        if (v) begin
            if (!m_in_pkt) begin
                m_grant0 = model_grant(tuser, af, 0);
                m_grant1 = model_grant(tuser, af, 1);
            end
            ew0 = m_grant0;
            ew1 = m_grant1;
            if (last) begin
                ep0 = m_grant0;
                ep1 = m_grant1;
                if (m_grant0 == '0) m_drops0++;
                if (m_grant1 == '0) m_drops1++;
            end
            m_in_pkt = !last;
        end
        exp_q.push_back({ew0, ep0, ew1, ep1});
        @(posedge clk);
        #1;
        e   = exp_q.pop_front();
        wr0 = bus0.m_axis_ctl_buffer_wr_en;
        p0  = bus0.m_axis_ctl_pifo_in_en;
        wr1 = bus1.m_axis_ctl_buffer_wr_en;
        p1  = bus1.m_axis_ctl_pifo_in_en;
        check("model_wr_partial",  32'(wr0), 32'(e[4*NP-1:3*NP]));
        check("model_pifo_partial", 32'(p0), 32'(e[3*NP-1:2*NP]));
        check("model_wr_aon",      32'(wr1), 32'(e[2*NP-1:NP]));
        check("model_pifo_aon",    32'(p1),  32'(e[NP-1:0]));
        check("tready_high",       32'(bus0.s_axis_tready & bus1.s_axis_tready), 32'd1);
`ifdef ENQ_AGENT_DROP_CNT_EN
        check("drop_count_partial", drop0, 32'(m_drops0));
        check("drop_count_aon",     drop1, 32'(m_drops1));
`endif
        @(negedge clk);
    endtask

    typedef struct {
        logic          v;
        logic [NP-1:0] mask;
        logic          last;
        logic [NP-1:0] af;
        logic [NP-1:0] wr0, p0, wr1, p1;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic v, input logic [NP-1:0] mask, input logic last,
                           input logic [NP-1:0] af, input logic [NP-1:0] wr0,
                           input logic [NP-1:0] p0, input logic [NP-1:0] wr1,
                           input logic [NP-1:0] p1);
        vec_t r;
        r.v = v; r.mask = mask; r.last = last; r.af = af;
        r.wr0 = wr0; r.p0 = p0; r.wr1 = wr1; r.p1 = p1;
        tbl.push_back(r);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_partial"},   32'(bus0.m_axis_ctl_buffer_wr_en), 32'd0);
        check({tag, "_pifo_partial"}, 32'(bus0.m_axis_ctl_pifo_in_en),   32'd0);
        check({tag, "_wr_aon"},       32'(bus1.m_axis_ctl_buffer_wr_en), 32'd0);
        check({tag, "_pifo_aon"},     32'(bus1.m_axis_ctl_pifo_in_en),   32'd0);
        check({tag, "_tready"},       32'(bus0.s_axis_tready | bus1.s_axis_tready), 32'd0);
`ifdef ENQ_AGENT_DROP_CNT_EN
        check({tag, "_drop_count"},   drop0 | drop1, 32'd0);
`endif
    endtask

    initial begin
        logic [NP-1:0] wr0, p0, wr1, p1;

        resetn                         = 1'b0;
        bus0.s_axis_tvalid             = 1'b0;
        bus0.s_axis_tuser              = '0;
        bus0.s_axis_tlast              = 1'b0;
        bus0.s_axis_buffer_almost_full = '0;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        check("reset_state_idle", 32'(bus0.dbg_state == ST_IDLE && bus1.dbg_state == ST_IDLE), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("tready_after_release", 32'(bus0.s_axis_tready), 32'd1);
        @(negedge clk);

        // directed vectors: v, dst mask, tlast, almost_full -> wr/pifo partial, wr/pifo all-or-none
        add_vec(0, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        add_vec(1, 5'b01001, 0, 5'b00000, 5'b01001, 5'b00000, 5'b01001, 5'b00000);
        add_vec(1, 5'b00000, 1, 5'b00000, 5'b01001, 5'b01001, 5'b01001, 5'b01001);
        add_vec(1, 5'b01110, 0, 5'b01110, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        add_vec(1, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        add_vec(1, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        add_vec(1, 5'b01110, 0, 5'b00110, 5'b01000, 5'b00000, 5'b00000, 5'b00000);
        add_vec(1, 5'b00000, 0, 5'b11111, 5'b01000, 5'b00000, 5'b00000, 5'b00000);
        add_vec(1, 5'b00000, 1, 5'b00000, 5'b01000, 5'b01000, 5'b00000, 5'b00000);
        add_vec(1, 5'b00100, 0, 5'b00000, 5'b00100, 5'b00000, 5'b00100, 5'b00000);
        add_vec(0, 5'b00000, 0, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        add_vec(1, 5'b00000, 0, 5'b00100, 5'b00100, 5'b00000, 5'b00100, 5'b00000);
        add_vec(1, 5'b00000, 1, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100);
        add_vec(1, 5'b10000, 1, 5'b00000, 5'b10000, 5'b10000, 5'b10000, 5'b10000);
        add_vec(1, 5'b00001, 0, 5'b00000, 5'b00001, 5'b00000, 5'b00001, 5'b00000);
        add_vec(1, 5'b00000, 1, 5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00001);
        add_vec(1, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        add_vec(1, 5'b00010, 1, 5'b01000, 5'b00010, 5'b00010, 5'b00010, 5'b00010);
        add_vec(1, 5'b00011, 1, 5'b00001, 5'b00010, 5'b00010, 5'b00000, 5'b00000);

        for (int k = 0; k < tbl.size(); k++) begin
            do_cycle(tbl[k].v, tbl[k].mask, tbl[k].last, tbl[k].af, wr0, p0, wr1, p1);
            check($sformatf("vec%0d_wr_partial", k),   32'(wr0), 32'(tbl[k].wr0));
            check($sformatf("vec%0d_pifo_partial", k), 32'(p0),  32'(tbl[k].p0));
            check($sformatf("vec%0d_wr_aon", k),       32'(wr1), 32'(tbl[k].wr1));
            check($sformatf("vec%0d_pifo_aon", k),     32'(p1),  32'(tbl[k].p1));
        end

        // reset during beat 2 of a 3-beat packet to port 1
        do_cycle(1, 5'b00010, 0, 5'b00000, wr0, p0, wr1, p1);
        do_cycle(1, 5'b00000, 0, 5'b00000, wr0, p0, wr1, p1);
        check("pre_reset_wr", 32'(wr0), 32'h2);
        bus0.s_axis_tvalid = 1'b1;
        bus0.s_axis_tlast  = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check_outputs_zero("midreset_async");
        @(posedge clk);
        #1;
        check_outputs_zero("midreset_held");
        @(negedge clk);
        resetn                         = 1'b1;
        bus0.s_axis_tvalid             = 1'b0;
        bus0.s_axis_tlast              = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("tready_after_midreset", 32'(bus0.s_axis_tready), 32'd1);
        check("no_pifo_after_midreset", 32'(bus0.m_axis_ctl_pifo_in_en), 32'd0);
        @(negedge clk);
        do_cycle(1, 5'b00100, 1, 5'b00000, wr0, p0, wr1, p1);
        check("post_reset_wr",   32'(wr0), 32'h4);
        check("post_reset_pifo", 32'(p0),  32'h4);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            do_cycle($urandom_range(0, 3) != 0, NP'($urandom_range(0, 31)),
                     $urandom_range(0, 2) == 0, NP'($urandom_range(0, 31)),
                     wr0, p0, wr1, p1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/enqueue_agent_v2.md
ENQUEUE_AGENT_V2 -- requirements
Module: enqueue_agent_v2

Interface
REQ-001 Parameter NUM_PORTS, default 5, number of output port queues (1..8).
REQ-002 Parameter TUSER_WIDTH, default 128, width of s_axis_tuser.
REQ-003 Parameter DST_POS, default 24, tuser bit of port 0 destination flag; port i flag at DST_POS+2*i.
REQ-004 Parameter DROP_MODE, default 0; 0 = partial enqueue to non-full ports, 1 = all-or-none.
REQ-005 axis_aclk  in  1  single clock; all logic on its rising edge.
REQ-006 axis_resetn  in  1  reset, asynchronous, active-low.
REQ-007 s_axis_tvalid  in  1  beat valid from pipeline.
REQ-008 s_axis_tready  out  1  beat accept.
REQ-009 s_axis_tuser  in  TUSER_WIDTH  sume metadata, sampled on first beat only.
REQ-010 s_axis_tlast  in  1  last beat of packet.
REQ-011 s_axis_buffer_almost_full  in  NUM_PORTS  per-port buffer almost-full status.
REQ-012 m_axis_ctl_buffer_wr_en  out  NUM_PORTS  per-port buffer write enable, one bit per accepted beat.
REQ-013 m_axis_ctl_pifo_in_en  out  NUM_PORTS  per-port PIFO enqueue pulse, one per packet.
REQ-014 m_drop_count  out  32  dropped-packet count (present only with ENQ_AGENT_DROP_CNT_EN).

Function
REQ-015 Beat accepted when s_axis_tvalid && s_axis_tready; s_axis_tready SHALL be 1 in every state from the first clock edge after reset release.
REQ-016 FSM states: IDLE, WRITE, DROP; IDLE means next accepted beat is a packet's first beat.
REQ-017 On first beat: dst[i] = tuser[DST_POS+2*i]; grant = dst & ~s_axis_buffer_almost_full.
REQ-018 DROP_MODE=1: grant forced to 0 if any (dst & almost_full) bit set.
REQ-019 First beat with grant != 0 and tlast=0 -> WRITE; grant == 0 and tlast=0 -> DROP; tlast=1 -> stay IDLE.
REQ-020 Grant SHALL be latched in a register and held constant until the packet's tlast beat; almost_full changes mid-packet are ignored.
REQ-021 For every accepted beat of a granted packet, m_axis_ctl_buffer_wr_en = grant for exactly one cycle, registered, one cycle after acceptance.
REQ-022 m_axis_ctl_pifo_in_en = grant for exactly one cycle, one cycle after tlast beat accepted (same cycle as last wr_en).
REQ-023 Dropped packets (grant == 0, incl. dst == 0) SHALL assert no wr_en and no pifo_in_en bits.
REQ-024 WRITE/DROP -> IDLE on accepted tlast beat; cycles with tvalid=0 hold state and drive outputs 0.
REQ-025 Single-beat packet: one wr_en pulse and one pifo_in_en pulse, same cycle.
REQ-026 Back-to-back packets with no idle cycle SHALL be supported; new grant computed on the beat following tlast.

Reset
REQ-027 While axis_resetn=0: state IDLE, grant 0, s_axis_tready 0, wr_en 0, pifo_in_en 0, m_drop_count 0.
REQ-028 Reset mid-packet SHALL abandon the packet with no pifo_in_en; first beat after release is a new packet.

Configuration
REQ-029 Macro ENQ_AGENT_DROP_CNT_EN defined: m_drop_count exists, increments by 1 one cycle after each dropped packet's tlast, saturates at 32'hFFFFFFFF.
REQ-030 ENQ_AGENT_DROP_CNT_EN undefined: port m_drop_count and its counter absent; all other behaviour identical.

Structure
REQ-031 Package enqueue_agent_pkg SHALL hold FSM state enum, DROP_MODE encodings (PARTIAL=0, ALL_OR_NONE=1), default DST_POS.
REQ-032 Single module; grant computation is a combinational function in the package, no sub-module.

Verification
REQ-033 Ports 0,3 dst, none full, 2 beats -> wr_en=5'b01001 two cycles, pifo_in_en=5'b01001 with second.
REQ-034 Ports 1,2,3 dst, almost_full=5'b01110, 3 beats -> no wr_en, no pifo_in_en, drop_count +1.
REQ-035 Ports 1,2,3 dst, almost_full=5'b00110, DROP_MODE=0 -> wr_en=5'b01000 x3, pifo_in_en=5'b01000; DROP_MODE=1 -> dropped.
REQ-036 almost_full rises on port 2 at beat 2 of a 3-beat port-2 packet -> all 3 wr_en=5'b00100, pifo_in_en=5'b00100.
REQ-037 Single-beat packet to port 4 followed immediately by 2-beat packet to port 0 -> 5'b10000 pulses, then 5'b00001 x2 with pifo on second.
REQ-038 axis_resetn low mid-packet (beat 2 of 3) -> outputs 0 immediately, no pifo_in_en, next packet enqueued normally.
